// File: rtl/sram_scan_driver.sv
`default_nettype none
// ============================================================================
// Module   : sram_scan_driver
// Purpose  : Serializing front end for the SRAM scan wrapper. Takes one
//            parallel command (address, burst count, read/write) and, for
//            writes, a stream of data words. Emits the single-bit scan stream
//            and the active-low scan reset that feed the wrapper's scan_in
//            and rst_n pins. Each command is framed as:
//              N_rst cycles of scan_rst_n low,
//              an LSB-first header {addr, cnt, write},
//              (cnt+1) LSB-first data words.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk          in   system clock, rising edge
//   rst          in   synchronous active-high reset
//   cmd_valid    in   command offered
//   cmd_ready    out  command accepted on cmd_valid & cmd_ready
//   cmd_addr     in   start address            [N_addr-1:0]
//   cmd_cnt      in   burst count (words-1)    [N_cnt-2:0]
//   cmd_write    in   1 = write burst, 0 = read burst
//   wdata_valid  in   write word offered
//   wdata_ready  out  write word accepted on wdata_valid & wdata_ready
//   wdata        in   write word               [N_data-1:0]
//   scan_rst_n   out  to wrapper rst_n
//   scan_data    out  to wrapper scan_in
//   busy         out  high whenever a command is in progress
//   done         out  one-cycle pulse during the final data bit
//   underrun     out  sticky: a write word was missing when needed
// ============================================================================
module sram_scan_driver #(
    parameter int N_addr = 31,
    parameter int N_cnt  = 32,
    parameter int N_data = 32,
    parameter int N_rst  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [N_addr-1:0] cmd_addr,
    input  logic [N_cnt-2:0]  cmd_cnt,
    input  logic              cmd_write,
    input  logic              wdata_valid,
    output logic              wdata_ready,
    input  logic [N_data-1:0] wdata,
    output logic              scan_rst_n,
    output logic              scan_data,
    output logic              busy,
    output logic              done,
    output logic              underrun
);

    // ------------------------------------------------------------------
    // Derived constants
    // ------------------------------------------------------------------
    localparam int HDR_W  = N_addr + N_cnt;      // header length in bits
    localparam int WB_W   = $clog2(N_data);      // in-word bit counter width
    localparam int RC_W   = $clog2(N_rst);       // reset-pulse counter width
    localparam int PF_LEN = 8;                   // prefetch window length

    localparam logic [5:0]      c_HDR_LAST  = 6'(HDR_W - 1);
    localparam logic [5:0]      c_HDR_PF    = 6'(HDR_W - PF_LEN);
    localparam logic [WB_W-1:0] c_WORD_LAST = WB_W'(N_data - 1);
    localparam logic [WB_W-1:0] c_WORD_PF   = WB_W'(N_data - PF_LEN);
    localparam logic [RC_W-1:0] c_RST_LAST  = RC_W'(N_rst - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RST  = 2'd1,
        S_HDR  = 2'd2,
        S_DAT  = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    // Counters always describe the bit currently on scan_data:
    //   r_bit_cnt  - header bit index being driven
    //   r_wbit     - data bit index within the current word
    //   r_word_cnt - words still to follow the current one
    state_t              r_state;
    logic [RC_W-1:0]     r_rst_cnt;
    logic [5:0]          r_bit_cnt;
    logic [WB_W-1:0]     r_wbit;
    logic [N_cnt-2:0]    r_word_cnt;
    logic [HDR_W-1:0]    r_hdr;      // bit 0 is the header bit on the wire
    logic [N_data-1:0]   r_shift;    // bit 0 is the data bit on the wire
    logic [N_data-1:0]   r_buf;      // prefetched next word
    logic                r_have;     // r_buf holds a word for the next load
    logic                r_write;

    state_t              w_state_nx;
    logic [RC_W-1:0]     w_rst_cnt_nx;
    logic [5:0]          w_bit_cnt_nx;
    logic [WB_W-1:0]     w_wbit_nx;
    logic [N_cnt-2:0]    w_word_cnt_nx;
    logic [HDR_W-1:0]    w_hdr_nx;
    logic [N_data-1:0]   w_shift_nx;
    logic [N_data-1:0]   w_buf_nx;
    logic                w_have_nx;
    logic                w_write_nx;
    logic                w_underrun_nx;

    logic                w_take;
    logic [N_data-1:0]   w_load_word;
    logic                w_word_missing;

    logic                w_cmd_ready_nx;
    logic                w_wdata_ready_nx;
    logic                w_scan_rst_n_nx;
    logic                w_scan_data_nx;
    logic                w_busy_nx;
    logic                w_done_nx;

    // ------------------------------------------------------------------
    // Next-state and datapath logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nx    = r_state;
        w_rst_cnt_nx  = r_rst_cnt;
        w_bit_cnt_nx  = r_bit_cnt;
        w_wbit_nx     = r_wbit;
        w_word_cnt_nx = r_word_cnt;
        w_hdr_nx      = r_hdr;
        w_shift_nx    = r_shift;
        w_buf_nx      = r_buf;
        w_have_nx     = r_have;
        w_write_nx    = r_write;
        w_underrun_nx = underrun;

        w_take = wdata_valid & wdata_ready;

        // A word handed over in the very last window cycle goes straight
        // into the shift register; the stream cannot wait for the buffer.
        w_load_word = '0;
        if (r_have) begin
            w_load_word = r_buf;
        end else if (w_take) begin
            w_load_word = wdata;
        end
        w_word_missing = r_write & ~r_have & ~w_take;

        if (w_take) begin
            w_buf_nx  = wdata;
            w_have_nx = 1'b1;
        end

        case (r_state)
            S_IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    w_state_nx    = S_RST;
                    w_rst_cnt_nx  = '0;
                    w_hdr_nx      = {cmd_addr, cmd_cnt, cmd_write};
                    w_word_cnt_nx = cmd_cnt;
                    w_write_nx    = cmd_write;
                    w_underrun_nx = 1'b0;
                    w_have_nx     = 1'b0;
                end
            end

            S_RST: begin
                if (r_rst_cnt == c_RST_LAST) begin
                    w_state_nx   = S_HDR;
                    w_bit_cnt_nx = '0;
                end else begin
                    w_rst_cnt_nx = r_rst_cnt + 1'b1;
                end
            end

            S_HDR: begin
                if (r_bit_cnt == c_HDR_LAST) begin
                    w_state_nx = S_DAT;
                    w_wbit_nx  = '0;
                    w_shift_nx = r_write ? w_load_word : '0;
                    w_have_nx  = 1'b0;
                    if (w_word_missing) begin
                        w_underrun_nx = 1'b1;
                    end
                end else begin
                    w_bit_cnt_nx = r_bit_cnt + 1'b1;
                    w_hdr_nx     = r_hdr >> 1;
                end
            end

            S_DAT: begin
                if (r_wbit == c_WORD_LAST) begin
                    if (r_word_cnt == '0) begin
                        w_state_nx = S_IDLE;
                    end else begin
                        w_word_cnt_nx = r_word_cnt - 1'b1;
                        w_wbit_nx     = '0;
                        w_shift_nx    = r_write ? w_load_word : '0;
                        w_have_nx     = 1'b0;
                        if (w_word_missing) begin
                            w_underrun_nx = 1'b1;
                        end
                    end
                end else begin
                    w_wbit_nx  = r_wbit + 1'b1;
                    w_shift_nx = r_shift >> 1;
                end
            end

            default: begin
                w_state_nx = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output decode from the next state, so every output is a flop and
    // lines up with the cycle in which that state is current.
    // ------------------------------------------------------------------
    always_comb begin
        w_cmd_ready_nx  = (w_state_nx == S_IDLE);
        w_busy_nx       = (w_state_nx != S_IDLE);
        w_scan_rst_n_nx = (w_state_nx != S_RST);

        w_scan_data_nx = 1'b0;
        if (w_state_nx == S_HDR) begin
            w_scan_data_nx = w_hdr_nx[0];
        end else if (w_state_nx == S_DAT) begin
            w_scan_data_nx = w_shift_nx[0];
        end

        w_done_nx = (w_state_nx == S_DAT) && (w_wbit_nx == c_WORD_LAST) &&
                    (w_word_cnt_nx == '0);

        // Fetch window: last PF_LEN header bits for word 0, last PF_LEN bits
        // of every non-final word for the word after it. Ready drops once a
        // word has been taken so only one word is accepted per window.
        w_wdata_ready_nx = w_write_nx & ~w_have_nx &
            (((w_state_nx == S_HDR) && (w_bit_cnt_nx >= c_HDR_PF)) ||
             ((w_state_nx == S_DAT) && (w_wbit_nx >= c_WORD_PF) &&
              (w_word_cnt_nx != '0)));
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_rst_cnt   <= '0;
            r_bit_cnt   <= '0;
            r_wbit      <= '0;
            r_word_cnt  <= '0;
            r_hdr       <= '0;
            r_shift     <= '0;
            r_buf       <= '0;
            r_have      <= 1'b0;
            r_write     <= 1'b0;
            underrun    <= 1'b0;
            cmd_ready   <= 1'b1;
            wdata_ready <= 1'b0;
            scan_rst_n  <= 1'b1;
            scan_data   <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            r_state     <= w_state_nx;
            r_rst_cnt   <= w_rst_cnt_nx;
            r_bit_cnt   <= w_bit_cnt_nx;
            r_wbit      <= w_wbit_nx;
            r_word_cnt  <= w_word_cnt_nx;
            r_hdr       <= w_hdr_nx;
            r_shift     <= w_shift_nx;
            r_buf       <= w_buf_nx;
            r_have      <= w_have_nx;
            r_write     <= w_write_nx;
            underrun    <= w_underrun_nx;
            cmd_ready   <= w_cmd_ready_nx;
            wdata_ready <= w_wdata_ready_nx;
            scan_rst_n  <= w_scan_rst_n_nx;
            scan_data   <= w_scan_data_nx;
            busy        <= w_busy_nx;
            done        <= w_done_nx;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sram_scan_driver.sv
`default_nettype none
// ============================================================================
// Module   : tb_sram_scan_driver
// Purpose  : Self-checking bench for sram_scan_driver. Expected waveforms are
//            computed per command from the frame layout (reset pulse, header,
//            data words, prefetch windows) and compared cycle by cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sram_scan_driver;

    localparam int N_ADDR = 31;
    localparam int N_CNT  = 32;
    localparam int N_DATA = 32;
    localparam int N_RST  = 4;
    localparam int HDR_W  = N_ADDR + N_CNT;
    localparam int MAXW   = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              cmd_valid;
    logic              cmd_ready;
    logic [N_ADDR-1:0] cmd_addr;
    logic [N_CNT-2:0]  cmd_cnt;
    logic              cmd_write;
    logic              wdata_valid;
    logic              wdata_ready;
    logic [N_DATA-1:0] wdata;
    logic              scan_rst_n;
    logic              scan_data;
    logic              busy;
    logic              done;
    logic              underrun;

    int n_checks = 0;
    int n_errors = 0;

    // Per-word offer delay into its prefetch window (>= 8 means withheld)
    int          dly  [MAXW];
    logic [31:0] wval [MAXW];

    sram_scan_driver #(
        .N_addr (N_ADDR),
        .N_cnt  (N_CNT),
        .N_data (N_DATA),
        .N_rst  (N_RST)
    ) u_dut (
        .clk         (clk),
        .rst         (rst),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_addr    (cmd_addr),
        .cmd_cnt     (cmd_cnt),
        .cmd_write   (cmd_write),
        .wdata_valid (wdata_valid),
        .wdata_ready (wdata_ready),
        .wdata       (wdata),
        .scan_rst_n  (scan_rst_n),
        .scan_data   (scan_data),
        .busy        (busy),
        .done        (done),
        .underrun    (underrun)
    );

    always #5 clk = ~clk;

    // Wrapper model: shifts scan_in on the falling edge, header first.
    logic [HDR_W-1:0] wrap_hdr = '0;
    int               wrap_cnt = 0;
    always @(negedge clk) begin
        if (rst || !scan_rst_n) begin
            wrap_cnt <= 0;
        end else if (wrap_cnt < HDR_W) begin
            wrap_hdr <= {scan_data, wrap_hdr[HDR_W-1:1]};
            wrap_cnt <= wrap_cnt + 1;
        end
    end

    task automatic check_val(input string tag, input logic [63:0] got,
                             input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_idle(input string tag, input logic exp_under);
        check_val({tag, "_rstn"},     scan_rst_n,  1);
        check_val({tag, "_data"},     scan_data,   0);
        check_val({tag, "_busy"},     busy,        0);
        check_val({tag, "_done"},     done,        0);
        check_val({tag, "_cmdrdy"},   cmd_ready,   1);
        check_val({tag, "_wrdy"},     wdata_ready, 0);
        check_val({tag, "_underrun"}, underrun,    exp_under);
    endtask

    // Runs one command. Entered at a falling edge; inputs set here apply to
    // the current cycle. Returns at the falling edge of the first cycle
    // after done (or after the abort reset cycle).
    task automatic run_cmd(input logic [N_ADDR-1:0] addr, input logic [N_CNT-2:0] cnt,
                           input logic wr, input bit hold, input bit expect_now,
                           input int abort_at);
        int               nw, e, waits, s, offer, hi, di;
        logic [HDR_W-1:0] h;
        logic [31:0]      words [MAXW];
        logic             exp_rstn, exp_data, exp_rdy, exp_under, any_withheld;

        nw = int'(cnt) + 1;
        h  = {addr, cnt, wr};
        e  = N_RST + HDR_W + nw * N_DATA;
        any_withheld = 1'b0;
        for (int k = 0; k < MAXW; k++) begin
            words[k] = (wr && dly[k] < 8) ? wval[k] : 32'h0;
            if (wr && k < nw && dly[k] >= 8) any_withheld = 1'b1;
        end

        cmd_addr    = addr;
        cmd_cnt     = cnt;
        cmd_write   = wr;
        cmd_valid   = 1'b1;
        wdata_valid = 1'b0;

        waits = 0;
        while (cmd_ready !== 1'b1 && waits < 50) begin
            @(negedge clk);
            waits++;
        end
        if (expect_now) check_val("b2b_gap", waits, 0);
        if (cmd_ready !== 1'b1) begin
            check_val("accept_timeout", cmd_ready, 1);
            cmd_valid = 1'b0;
            return;
        end

        for (int i = 1; i <= e; i++) begin
            @(negedge clk);
            hi = i - 1 - N_RST;
            di = hi - HDR_W;
            exp_rstn = (i > N_RST);
            if (hi >= 0 && hi < HDR_W)  exp_data = h[hi];
            else if (di >= 0)           exp_data = words[di / N_DATA][di % N_DATA];
            else                        exp_data = 1'b0;
            exp_rdy   = 1'b0;
            exp_under = 1'b0;
            if (wr) begin
                for (int k = 0; k < nw; k++) begin
                    s     = 1 + N_RST + HDR_W + k * N_DATA;
                    offer = (dly[k] >= 8) ? s - 1 : s - 8 + dly[k];
                    if (dly[k] >= 8 && i >= s) exp_under = 1'b1;
                    if (i >= s - 8 && i <= offer) exp_rdy = 1'b1;
                end
            end
            check_val("scan_rst_n",  scan_rst_n,  exp_rstn);
            check_val("scan_data",   scan_data,   exp_data);
            check_val("done",        done,        (i == e));
            check_val("busy",        busy,        1);
            check_val("cmd_ready",   cmd_ready,   0);
            check_val("wdata_ready", wdata_ready, exp_rdy);
            check_val("underrun",    underrun,    exp_under);

            if (i == abort_at) begin
                rst = 1'b1;
                cmd_valid = 1'b0;
                wdata_valid = 1'b0;
                @(negedge clk);
                check_idle("abort", 1'b0);
                rst = 1'b0;
                return;
            end

            // Inputs for cycle i
            cmd_valid   = hold;
            wdata_valid = 1'b0;
            wdata       = $urandom;
            if (wr) begin
                for (int k = 0; k < nw; k++) begin
                    s = 1 + N_RST + HDR_W + k * N_DATA;
                    if (dly[k] < 8 && i >= s - 8 + dly[k] && i <= s - 1) begin
                        // Keep offering a different word after the hand-over
                        // so a second take in the same window would show.
                        wdata_valid = 1'b1;
                        wdata = (i == s - 8 + dly[k]) ? wval[k] : ~wval[k];
                    end
                end
            end else begin
                wdata_valid = 1'($urandom_range(0, 1));
            end
        end

        wdata_valid = 1'b0;
        @(negedge clk);
        check_idle("post", any_withheld);
        check_val("wrap_hdr", wrap_hdr, h);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit          hold, prev_hold;
        int          gap;
        logic [30:0] a;

        rst = 1'b1; cmd_valid = 1'b0; cmd_addr = '0; cmd_cnt = '0;
        cmd_write = 1'b0; wdata_valid = 1'b0; wdata = '0;
        for (int k = 0; k < MAXW; k++) begin
            dly[k]  = 0;
            wval[k] = 32'h0;
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_idle("reset", 1'b0);

        // Single-word write
        dly[0] = 0; wval[0] = 32'hA5A5_0F0F;
        run_cmd(31'h005, 31'd0, 1'b1, 1'b0, 1'b0, 0);

        // Three-word read
        run_cmd(31'h3FF, 31'd2, 1'b0, 1'b0, 1'b0, 0);

        // Two-word write, second word withheld
        dly[0] = 3; wval[0] = $urandom; dly[1] = 8; wval[1] = $urandom;
        run_cmd(31'h0ABC, 31'd1, 1'b1, 1'b0, 1'b0, 0);
        repeat (3) begin
            @(negedge clk);
            check_val("underrun_sticky", underrun, 1);
        end

        // Reset during header bit 20
        run_cmd(31'h123, 31'd0, 1'b0, 1'b0, 1'b0, 1 + N_RST + 20);

        // Back-to-back writes with cmd_valid held high
        dly[0] = 2; wval[0] = $urandom;
        run_cmd(31'h1111, 31'd0, 1'b1, 1'b1, 1'b0, 0);
        dly[0] = 7; wval[0] = $urandom; dly[1] = 0; wval[1] = $urandom;
        run_cmd(31'h2222, 31'd1, 1'b1, 1'b0, 1'b1, 0);

        // Random commands
        prev_hold = 1'b0;
        for (int r = 0; r < 8; r++) begin
            for (int k = 0; k < MAXW; k++) begin
                dly[k]  = $urandom_range(0, 9);
                wval[k] = $urandom;
            end
            hold = (r < 7) ? 1'($urandom_range(0, 1)) : 1'b0;
            a    = 31'($urandom);
            run_cmd(a, 31'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                    hold, prev_hold, 0);
            prev_hold = hold;
            if (!hold) begin
                gap = $urandom_range(0, 2);
                repeat (gap) begin
                    @(negedge clk);
                    check_val("idle_busy", busy, 0);
                end
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sram_scan_driver.md
# sram_scan_driver

Serializing front end for the SRAM scan wrapper. Accepts a parallel command (address, burst count, read/write) and, for writes, a stream of 32-bit data words. It emits the single-bit scan stream and active-low scan reset that the wrapper's `scan_in` and `rst_n` pins consume. Each command is framed by a scan reset pulse, an LSB-first 63-bit header, and LSB-first data words.

## Interface

Parameters:
- N_addr, 31, address bits in header
- N_cnt, 32, count field bits in header (bit 0 = write flag, bits N_cnt-1:1 = burst count)
- N_data, 32, data word width
- N_rst, 4, cycles `scan_rst_n` is held low before each command (minimum 2)

Ports:
- clk  in  1  single system clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  command accepted when `cmd_valid & cmd_ready`
- cmd_addr  in  N_addr  start address
- cmd_cnt  in  N_cnt-1  burst count; words transferred = cmd_cnt+1
- cmd_write  in  1  1 = write burst, 0 = read burst
- wdata_valid  in  1  write word offered
- wdata_ready  out  1  word accepted when `wdata_valid & wdata_ready`
- wdata  in  N_data  write word
- scan_rst_n  out  1  to wrapper `rst_n`
- scan_data  out  1  to wrapper `scan_in`
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse on last data bit
- underrun  out  1  sticky; set when a write word was not available in time; cleared only by `rst` or a new command accept

## Operation

- Header word: H = {cmd_addr, cmd_cnt, cmd_write}, 63 bits. H[0] = cmd_write is sent first, and H[62] = cmd_addr MSB is sent last.
- FSM states:
  - IDLE: cmd_ready=1, scan_rst_n=1, scan_data=0. On accept, latch H and the word counter (cmd_cnt), clear underrun, go to RST.
  - RST: scan_rst_n=0, scan_data=0 for exactly N_rst cycles, then go to HDR.
  - HDR: scan_rst_n=1, scan_data=H[bit_cnt]. bit_cnt runs 0..62. After bit 62, go to DAT.
  - DAT: shift the data shift register LSB-first, N_data bits per word, word_cnt+1 words.
    - Write: each word is loaded from wdata.
    - Read: all-zero words are sent to keep the wrapper clocked through the burst.
    - After the last bit of the last word, pulse done and go to IDLE.
- Word prefetch (writes only):
  - wdata_ready=1 while a fetch is pending: in HDR from bit 55 onward, and in DAT for the last 8 bits of every word except the final one.
  - The word accepted in that window becomes the next shift-register load.
  - If no word has been accepted by the cycle the new word's bit 0 must be driven, load 0 and set underrun. The stream never stalls, because the wrapper shifts every clock.
  - A word accepted in the first pending cycle and a second word offered later in the same window: only one word is taken per window (wdata_ready drops after accept).
- Widths: bit_cnt is 6 bits, the in-word counter is log2(N_data) bits, word_cnt is N_cnt-1 bits and counts down to 0.
- cmd_cnt = 0 means a single word. cmd_cnt = all ones means 2^31 words; no wrap protection is needed because word_cnt terminates at 0.
- rst in any state: next cycle IDLE, scan_rst_n=1, scan_data=0, cmd_ready=1, wdata_ready=0, busy=0, done=0, underrun=0. A burst aborted mid-stream is not resumed.

## Timing

- Reset values: scan_rst_n=1, scan_data=0, cmd_ready=1 (from the first cycle after rst deasserts), wdata_ready=0, busy=0, done=0, underrun=0.
- Accept at edge T:
  - scan_rst_n falls at T+1 and rises at T+1+N_rst.
  - H[0] is driven on scan_data at the same edge scan_rst_n rises, so the wrapper samples both on one falling edge.
  - Header bit k is at edge T+1+N_rst+k.
  - Data bit 0 of word 0 is at T+1+N_rst+63.
  - done is high during the final data bit cycle, T+N_rst+63+(cmd_cnt+1)*N_data.
- cmd_ready returns high the cycle after done. Minimum command-to-command spacing is N_rst+63+(cmd_cnt+1)*N_data+1 cycles.
- All outputs are registered; scan_data and scan_rst_n have no combinational path from inputs.

## Test plan

- Reset mid-HDR (rst at header bit 20) -> next cycle scan_rst_n=1, scan_data=0, busy=0, cmd_ready=1.
- Write addr=0x005, cnt=0, wdata=0xA5A5_0F0F offered early -> 4 low cycles of scan_rst_n. Then 63 header bits: LSB first, bit0=1, bits[31:1]=0, bits[62:32]=0x005. Then 32 bits 0xA5A5_0F0F LSB first; done on the last bit; underrun=0.
- Read addr=0x3FF, cnt=2 -> header bit0=0, cnt field=2, addr field=0x3FF; 96 zero data bits; wdata_ready never asserted; done once.
- Write cnt=1, second word withheld -> word 1 shifts as 0x0000_0000, underrun=1 and stays set until the next cmd accept.
- Back-to-back writes with cmd_valid held high -> second accept occurs exactly one cycle after the first done; scan_rst_n pulses low again for 4 cycles.
- Bench model of the wrapper shift register (63-bit header register then 32-bit data register, shifting on the falling edge) -> captured header equals {addr, cnt, write} for 8 random commands.
